// File: rtl/pkg_ram.sv
// Shared RAM access types and arbiter constants.
package pkg_ram;

  localparam int unsigned RAM_ADDRW    = 16;
  localparam int unsigned ARB_LOCK_MAX = 8;

  typedef enum logic [1:0] {
    RAM_NOP   = 2'd0,
    RAM_FETCH = 2'd1,
    RAM_STORE = 2'd2
  } op_t;

  typedef enum logic [1:0] {
    RAM_BYTE  = 2'd0,
    RAM_HALF  = 2'd1,
    RAM_WORD  = 2'd2,
    RAM_DWORD = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: fixed port-0 priority or round-robin on a tie.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio,
  output logic [1:0] win
);

  // On a tie the port not served last wins, unless port 0 has priority.
  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = (prio || last) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the single-ported RAM: serialises accesses, absorbs the
// read latency and returns read data alongside a one-cycle ack.
module ram_arbiter
  import pkg_ram::*;
#(
  parameter int unsigned ADDRW  = RAM_ADDRW,
  parameter int unsigned DATAW  = 64,
  parameter int unsigned RD_LAT = 1,
  parameter bit          PRIO0  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       lock,
  input  op_t              op0,
  input  op_t              op1,
  input  size_t            size0,
  input  size_t            size1,
  input  logic [ADDRW-1:0] addr0,
  input  logic [ADDRW-1:0] addr1,
  input  logic [DATAW-1:0] wdata0,
  input  logic [DATAW-1:0] wdata1,
  output logic [1:0]       gnt,
  output logic [1:0]       ack,
  output logic [DATAW-1:0] rdata,
  output op_t              ram_op,
  output size_t            ram_size,
  output logic [ADDRW-1:0] ram_addr,
  output logic [DATAW-1:0] ram_wdata,
  input  logic [DATAW-1:0] ram_rdata,
  output logic             busy
);

  localparam logic [2:0] WaitLoad = 3'(RD_LAT - 1);
  localparam logic [3:0] LockLast = 4'(ARB_LOCK_MAX - 1);

  arb_state_t       state_q;
  logic [1:0]       gnt_q, ack_q;
  logic [2:0]       cnt_q;
  logic [3:0]       lock_cnt_q;
  logic             last_q, force_q;
  op_t              op_q;
  size_t            size_q;
  logic [ADDRW-1:0] addr_q;
  logic [DATAW-1:0] wdata_q;

  op_t              sel_op;
  size_t            sel_size;
  logic [ADDRW-1:0] sel_addr;
  logic [DATAW-1:0] sel_wdata;
  logic [1:0]       win;
  logic             gidx, pick_prio, other_req, lock_hold, lock_expire;

  assign gidx      = gnt_q[1];
  assign other_req = req[!gidx];
  assign lock_hold = lock[gidx] & req[gidx];
  // A lock is cut short only while the other port is actually waiting.
  assign lock_expire = other_req && (lock_cnt_q == LockLast);
  // After a forced release the starved port must win even under fixed priority.
  assign pick_prio = PRIO0 & ~force_q;

  rr_pick2 u_pick (
    .req  (req),
    .last (last_q),
    .prio (pick_prio),
    .win  (win)
  );

  always_comb begin
    sel_op    = gidx ? op1    : op0;
    sel_size  = gidx ? size1  : size0;
    sel_addr  = gidx ? addr1  : addr0;
    sel_wdata = gidx ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      cnt_q      <= '0;
      lock_cnt_q <= '0;
      last_q     <= 1'b0;
      force_q    <= 1'b0;
      op_q       <= RAM_NOP;
      size_q     <= RAM_BYTE;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (win != 2'b00) begin
            gnt_q      <= win;
            lock_cnt_q <= '0;
            force_q    <= 1'b0;
            state_q    <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          op_q    <= sel_op;
          size_q  <= sel_size;
          addr_q  <= sel_addr;
          wdata_q <= sel_wdata;
          if (sel_op == RAM_FETCH) begin
            cnt_q   <= WaitLoad;
            state_q <= ARB_WAIT;
          end else begin
            ack_q   <= gnt_q;
            state_q <= ARB_ACK;
          end
        end
        ARB_WAIT: begin
          if (cnt_q == 3'd0) begin
            ack_q   <= gnt_q;
            state_q <= ARB_ACK;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ARB_ACK: begin
          last_q <= gidx;
          if (lock_hold && !lock_expire) begin
            lock_cnt_q <= other_req ? lock_cnt_q + 4'd1 : 4'd0;
            state_q    <= ARB_ISSUE;
          end else begin
            gnt_q   <= '0;
            force_q <= lock_hold;
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // RAM bus follows the requester only during issue; otherwise it holds the
  // captured access so address and size stay stable while data returns.
  always_comb begin
    if (state_q == ARB_ISSUE) begin
      ram_op    = sel_op;
      ram_size  = sel_size;
      ram_addr  = sel_addr;
      ram_wdata = sel_wdata;
    end else begin
      ram_op    = RAM_NOP;
      ram_size  = size_q;
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
    end
    rdata = ((state_q == ARB_ACK) && (op_q == RAM_FETCH)) ? ram_rdata : '0;
  end

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign busy = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: three instances (RR lat 1, PRIO0 lat 1, RR lat 3).
module tb_ram_arbiter;
  import pkg_ram::*;

  typedef struct {
    int          inst;
    int          port;
    op_t         op;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req    [3];
  logic [1:0]  lock   [3];
  op_t         op0    [3];
  op_t         op1    [3];
  size_t       size0  [3];
  size_t       size1  [3];
  logic [15:0] addr0  [3];
  logic [15:0] addr1  [3];
  logic [63:0] wdata0 [3];
  logic [63:0] wdata1 [3];
  logic [1:0]  gnt    [3];
  logic [1:0]  ack    [3];
  logic [63:0] rdata  [3];
  op_t         ram_op [3];
  size_t       ram_size  [3];
  logic [15:0] ram_addr  [3];
  logic [63:0] ram_wdata [3];
  logic        busy   [3];

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  bit   gap_chk = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] rom(logic [15:0] a);
    return (a == 16'h0010) ? 64'h0000_0000_DEAD_BEEF : {32'hC0DE_0000, 16'h0000, a};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int unsigned Lat  = (g == 2) ? 3 : 1;
    localparam bit          Prio = (g == 1);
    logic [63:0] ram_rdata;
    logic [15:0] raddr = '0;
    int          rcnt = 0;
    bit          rvalid = 1'b0;

    ram_arbiter #(
      .ADDRW  (16),
      .DATAW  (64),
      .RD_LAT (Lat),
      .PRIO0  (Prio)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req[g]),
      .lock      (lock[g]),
      .op0       (op0[g]),
      .op1       (op1[g]),
      .size0     (size0[g]),
      .size1     (size1[g]),
      .addr0     (addr0[g]),
      .addr1     (addr1[g]),
      .wdata0    (wdata0[g]),
      .wdata1    (wdata1[g]),
      .gnt       (gnt[g]),
      .ack       (ack[g]),
      .rdata     (rdata[g]),
      .ram_op    (ram_op[g]),
      .ram_size  (ram_size[g]),
      .ram_addr  (ram_addr[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_rdata (ram_rdata),
      .busy      (busy[g])
    );

    // RAM data_out is valid Lat cycles after a fetch issue and holds afterwards.
    always @(posedge clk) begin
      if (ram_op[g] == RAM_FETCH) begin
        raddr  <= ram_addr[g];
        rcnt   <= Lat;
        rvalid <= 1'b1;
      end else if (rcnt != 0) begin
        rcnt <= rcnt - 1;
      end
    end
    assign ram_rdata = (rvalid && rcnt <= 1) ? rom(raddr) : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  function automatic void chk(string name, int inst, logic [63:0] act, logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s inst%0d: got %h want %h", name, inst, act, want);
    end
  endfunction

  function automatic void expect_acc(int inst, int port, op_t op, logic [15:0] a,
                                     logic [63:0] wd, logic [63:0] rd, int lat);
    exp_t e;
    e.inst = inst; e.port = port; e.op = op; e.addr = a;
    e.wdata = wd; e.rdata = rd; e.lat = lat;
    sbq.push_back(e);
  endfunction

  task automatic set_port(int i, int p, op_t op, logic [15:0] a, logic [63:0] wd);
    if (p == 0) begin
      op0[i] = op; size0[i] = RAM_DWORD; addr0[i] = a; wdata0[i] = wd;
    end else begin
      op1[i] = op; size1[i] = RAM_WORD; addr1[i] = a; wdata1[i] = wd;
    end
  endtask

  task automatic wait_done(int i);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (sbq.size() != 0 && n < 300);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL timeout inst%0d: got %0d pending, want 0", i, sbq.size());
      sbq.delete();
    end
    #1;
  endtask

  // Monitor: pops the scoreboard on every ack and checks the whole access.
  initial begin
    int          lat [3];
    int          idle[3];
    bit          aft [3];
    bit          bad [3];
    int          isn [3];
    op_t         iop [3];
    logic [63:0] iwd [3];
    logic [1:0]  pg  [3];
    logic [1:0]  want;
    exp_t        e;
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0; idle[i] = 0; aft[i] = 0; bad[i] = 0; isn[i] = 0;
      iop[i] = RAM_NOP; iwd[i] = '0; pg[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          lat[i] = 0; idle[i] = 0; aft[i] = 0; bad[i] = 0; isn[i] = 0; pg[i] = '0;
          continue;
        end
        if (gnt[i] != 2'b00) begin
          lat[i]++;
          if (pg[i] == 2'b00 && aft[i] && gap_chk) chk("idle_gap", i, 64'(idle[i]), 64'd1);
          if (pg[i] == 2'b00) aft[i] = 1'b0;
          if (sbq.size() > 0 && sbq[0].inst == i) begin
            if (ram_addr[i] !== sbq[0].addr) bad[i] = 1'b1;
            if (ram_op[i] != RAM_NOP) begin
              isn[i]++;
              iop[i] = ram_op[i];
              iwd[i] = ram_wdata[i];
            end
          end
        end else begin
          lat[i] = 0;
          idle[i]++;
        end
        if (ack[i] != 2'b00) begin
          if (sbq.size() == 0 || sbq[0].inst != i) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack inst%0d: got ack=%b want none", i, ack[i]);
          end else begin
            e = sbq.pop_front();
            want = (e.port == 0) ? 2'b01 : 2'b10;
            chk("ack_port", i, 64'(ack[i]), 64'(want));
            chk("ack_in_gnt", i, 64'(ack[i] & ~gnt[i]), 64'd0);
            chk("gnt_onehot", i, 64'($countones(gnt[i])), 64'd1);
            chk("rdata", i, rdata[i], e.rdata);
            chk("latency", i, 64'(lat[i]), 64'(e.lat));
            chk("addr_stable", i, 64'(bad[i]), 64'd0);
            chk("issue_cnt", i, 64'(isn[i]), (e.op == RAM_NOP) ? 64'd0 : 64'd1);
            if (e.op != RAM_NOP) chk("issue_op", i, 64'(iop[i]), 64'(e.op));
            if (e.op == RAM_STORE) chk("issue_wdata", i, iwd[i], e.wdata);
          end
          lat[i] = 0; isn[i] = 0; bad[i] = 1'b0; idle[i] = 0;
          aft[i] = gap_chk;
        end
        pg[i] = gnt[i];
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = '0; lock[i] = '0;
      set_port(i, 0, RAM_NOP, 16'h0, 64'h0);
      set_port(i, 1, RAM_NOP, 16'h0, 64'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_gnt", i, 64'(gnt[i]), 64'd0);
      chk("rst_ack", i, 64'(ack[i]), 64'd0);
      chk("rst_rdata", i, rdata[i], 64'd0);
      chk("rst_busy", i, 64'(busy[i]), 64'd0);
      chk("rst_ram_op", i, 64'(ram_op[i]), 64'(RAM_NOP));
      chk("rst_ram_size", i, 64'(ram_size[i]), 64'(RAM_BYTE));
      chk("rst_ram_addr", i, 64'(ram_addr[i]), 64'd0);
      chk("rst_ram_wdata", i, ram_wdata[i], 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single fetch on port 0, grant visible after one edge.
    set_port(0, 0, RAM_FETCH, 16'h0010, 64'h0);
    expect_acc(0, 0, RAM_FETCH, 16'h0010, 64'h0, 64'h0000_0000_DEAD_BEEF, 3);
    req[0] = 2'b01;
    @(posedge clk);
    #1;
    chk("grant_next_cycle", 0, 64'(gnt[0]), 64'd1);
    wait_done(0);
    req[0] = 2'b00;

    // Unsupported op behaves as an empty store.
    set_port(0, 0, RAM_NOP, 16'h0030, 64'h0);
    expect_acc(0, 0, RAM_NOP, 16'h0030, 64'h0, 64'h0, 2);
    req[0] = 2'b01;
    wait_done(0);
    req[0] = 2'b00;

    // Port 1 store; leaves port 1 as last served.
    set_port(0, 1, RAM_STORE, 16'h0200, 64'hAA);
    expect_acc(0, 1, RAM_STORE, 16'h0200, 64'hAA, 64'h0, 2);
    req[0] = 2'b10;
    wait_done(0);
    req[0] = 2'b00;

    // Round-robin: both request continuously, grants alternate with one idle cycle.
    set_port(0, 0, RAM_FETCH, 16'h0010, 64'h0);
    set_port(0, 1, RAM_FETCH, 16'h0040, 64'h0);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) expect_acc(0, 0, RAM_FETCH, 16'h0010, 64'h0, 64'h0000_0000_DEAD_BEEF, 3);
      else expect_acc(0, 1, RAM_FETCH, 16'h0040, 64'h0, 64'hC0DE_0000_0000_0040, 3);
    end
    gap_chk = 1'b1;
    req[0] = 2'b11;
    wait_done(0);
    req[0] = 2'b00;
    gap_chk = 1'b0;

    // Fixed priority: port 1 waits until port 0 lets go.
    set_port(1, 0, RAM_FETCH, 16'h0010, 64'h0);
    set_port(1, 1, RAM_FETCH, 16'h0040, 64'h0);
    for (int k = 0; k < 4; k++)
      expect_acc(1, 0, RAM_FETCH, 16'h0010, 64'h0, 64'h0000_0000_DEAD_BEEF, 3);
    req[1] = 2'b11;
    wait_done(1);
    req[1] = 2'b10;
    expect_acc(1, 1, RAM_FETCH, 16'h0040, 64'h0, 64'hC0DE_0000_0000_0040, 3);
    wait_done(1);
    req[1] = 2'b00;

    // Locked port 1 stores: eight back-to-back, then port 0 breaks in.
    set_port(0, 1, RAM_STORE, 16'h0100, 64'h55);
    set_port(0, 0, RAM_FETCH, 16'h0010, 64'h0);
    for (int k = 0; k < 8; k++)
      expect_acc(0, 1, RAM_STORE, 16'h0100, 64'h55, 64'h0, 2);
    expect_acc(0, 0, RAM_FETCH, 16'h0010, 64'h0, 64'h0000_0000_DEAD_BEEF, 3);
    lock[0] = 2'b10;
    req[0]  = 2'b10;
    @(posedge clk);
    #1;
    req[0] = 2'b11;
    wait_done(0);
    req[0]  = 2'b00;
    lock[0] = 2'b00;

    // Longer read latency: three wait cycles, five cycles grant to ack.
    set_port(2, 0, RAM_FETCH, 16'h0020, 64'h0);
    expect_acc(2, 0, RAM_FETCH, 16'h0020, 64'h0, 64'hC0DE_0000_0000_0020, 5);
    req[2] = 2'b01;
    wait_done(2);
    req[2] = 2'b00;

    // Asynchronous reset in the wait state abandons the access.
    set_port(2, 1, RAM_FETCH, 16'h0040, 64'h0);
    expect_acc(2, 1, RAM_FETCH, 16'h0040, 64'h0, 64'hC0DE_0000_0000_0040, 5);
    req[2] = 2'b10;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 2, 64'(gnt[2]), 64'd0);
    chk("async_rst_ack", 2, 64'(ack[2]), 64'd0);
    chk("async_rst_ram_op", 2, 64'(ram_op[2]), 64'(RAM_NOP));
    chk("async_rst_busy", 2, 64'(busy[2]), 64'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_acc(2, 1, RAM_FETCH, 16'h0040, 64'h0, 64'hC0DE_0000_0000_0040, 5);
    wait_done(2);
    req[2] = 2'b00;

    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-ported RAM device between two requesters: port 0 is the control unit (instruction and data fetch/store), port 1 is the boot/debug loader (program download, memory inspection).
- Sits between the requesters and the RAM, and owns the RAM op/size/addr/data_in signals.
- Serialises accesses, absorbs the fixed RAM read latency, and returns read data with a one-cycle ack pulse.
- Round-robin fairness, with an optional lock that lets one port hold the RAM for back-to-back accesses.

Parameters:
- ADDRW, 16, RAM byte-address width (equals pkg_ram::RAM_ADDRW).
- DATAW, 64, RAM data width.
- RD_LAT, 1, cycles from RAM op issue to valid data_out; legal range 1..7.
- PRIO0, 0, 1 = port 0 has fixed priority over port 1; 0 = round-robin.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- req[1:0]  in  2  per-port access request; held until ack
- lock[1:0]  in  2  per-port: keep grant after current access
- op0, op1  in  pkg_ram::op_t  RAM_FETCH or RAM_STORE; sampled at grant
- size0, size1  in  pkg_ram::size_t  access size
- addr0, addr1  in  ADDRW  byte address
- wdata0, wdata1  in  DATAW  store data
- gnt[1:0]  out  2  one-hot; port currently owning the RAM
- ack[1:0]  out  2  one-cycle pulse; access complete
- rdata  out  DATAW  read data; valid only while ack is high
- ram_op  out  pkg_ram::op_t  to RAM
- ram_size  out  pkg_ram::size_t  to RAM
- ram_addr  out  ADDRW  to RAM
- ram_wdata  out  DATAW  to RAM
- ram_rdata  in  DATAW  from RAM data_out
- busy  out  1  high in any state other than ARB_IDLE

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = ARB_IDLE; gnt = 0; ack = 0; rdata = 0; busy = 0.
  - ram_op = RAM_NOP; ram_size = RAM_BYTE; ram_addr = 0; ram_wdata = 0.
  - Round-robin pointer = port 0; latency counter = 0.
- Reset mid-access: the access is abandoned, no ack is issued, and the requester must re-request. A store already presented to the RAM may have completed.
- ARB_IDLE:
  - Picks a winner from req.
  - PRIO0 = 1: port 0 always wins a tie.
  - PRIO0 = 0: on a tie, the port not granted last wins.
  - On a pick: gnt is set one-hot and the state moves to ARB_ISSUE on the next edge.
  - No req: stay in ARB_IDLE; ram_op = RAM_NOP.
- ARB_ISSUE (exactly one cycle):
  - ram_op/size/addr/wdata are driven combinationally from the granted port.
  - The granted port's op/size/addr/wdata are captured into registers on this edge.
  - RAM_STORE: go to ARB_ACK.
  - RAM_FETCH: load the counter with RD_LAT-1 and go to ARB_WAIT.
- ARB_WAIT:
  - ram_op = RAM_NOP; ram_size/addr hold the captured values.
  - The counter decrements each cycle; at 0, go to ARB_ACK.
  - With RD_LAT = 1, ARB_WAIT lasts one cycle.
- ARB_ACK (one cycle):
  - ack[granted] = 1.
  - FETCH: rdata = ram_rdata. STORE: rdata = 0.
  - The round-robin pointer is updated to the granted port.
- Leaving ARB_ACK:
  - If lock[granted] and req[granted] are both high: stay granted and go to ARB_ISSUE.
  - Otherwise: gnt = 0 and go to ARB_IDLE.
- Access latency:
  - Fetch: RD_LAT+2 cycles from grant (ARB_ISSUE + RD_LAT wait cycles + ARB_ACK).
  - Store: 2 cycles.
- Requester rules:
  - After ack, the requester deasserts req or presents the next request.
  - A req present on the cycle after ack is a new access.
  - A requester that drops req before ack has its access completed anyway; the ack is still pulsed.
- Lock starvation guard:
  - A lock is honoured for at most 8 consecutive accesses while the other port requests.
  - The 9th access forces ARB_IDLE, and the other port then wins.
- Invariants: gnt is never 2'b11; ack is never 2'b11; ack is a subset of gnt.
- Unsupported op (RAM_NOP on req): treated as a store of nothing. ram_op stays RAM_NOP; ack follows after 2 cycles.

Decomposition:
- Into pkg_ram: arb_state_t (ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_ACK) and the constant ARB_LOCK_MAX = 8.
- Sub-module rr_pick2: a combinational 2-way round-robin/priority picker taking req, last, and prio, and returning the one-hot winner.
- Datapath muxing and the FSM stay in ram_arbiter.

Test Plan:
1. Reset, then port 0 fetches addr 0x0010, RD_LAT = 1, RAM returns 0xDEADBEEF. Required: gnt = 01 next cycle; ram_op = FETCH one cycle; ack[0] plus rdata = 0xDEADBEEF 3 cycles after grant.
2. Both ports request every cycle, PRIO0 = 0, lock = 0. Required: grants alternate 01, 10, 01, ...; each ack precedes the next grant by exactly one idle cycle.
3. Same stimulus with PRIO0 = 1. Required: port 1 never granted while req[0] is held.
4. Port 1 stores 0x55 at 0x0100 with lock[1] = 1 while port 0 requests continuously. Required: exactly 8 port 1 accesses, then port 0 granted.
5. Set RD_LAT = 3 and fetch. Required: ARB_WAIT lasts 3 cycles; ack 5 cycles after grant; ram_addr is stable throughout.
6. Assert rst_n = 0 during ARB_WAIT. Required: gnt, ack, and ram_op go to 0/NOP immediately (asynchronously); after release, the re-issued request completes normally.
